mem_port_arbiter: RTL and testbench

Arbitrates the single shared data/instruction memory port of the RV32 core between the instruction-fetch requester (IF) and the load/store requester (MEM stage). Issues one transaction per cycle into a fixed-latency synchronous memory, tracks the outstanding read, routes the returning data to its owner and produces per-requester stall signals for the hazard logic. Data accesses win by default; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/arb_starve_cnt.sv | 19 +
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;
  localparam logic [2:0] WIDTH_WORD = 3'b010;
  localparam int LAT_W = 3;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of denied fetch arbitration cycles
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);
  logic [STARVE_W-1:0] cnt_q, cnt_d;
  assign at_max_o = cnt_q == STARVE_W'(MAX);
  always_comb cnt_d = clr_i ? '0 : (inc_i && !at_max_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and load/store
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_kill_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [2:0]  d_width_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic [31:0] m_addr_o,
  output logic [2:0]  m_width_o,
  output logic        m_we_o,
  output logic [31:0] m_wdata_o,
  input  logic [31:0] m_rdata_i,
  output logic        stall_if_o,
  output logic        stall_mem_o
);
  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               killed_q, killed_d;
  logic [31:0]        if_rdata_q, d_rdata_q;
  logic               ret, arb, at_max, if_win, d_win, new_rd;
  assign ret    = state_q == WAIT && lat_q == LAT_W'(LAT);
  // gating with reset keeps grants and the memory command quiet while held in reset
  assign arb    = rst_ni && (state_q == IDLE || ret);
  assign if_win = arb && if_req_i && (at_max || !d_req_i);
  assign d_win  = arb && d_req_i && !if_win;
  assign new_rd = if_win || (d_win && !d_we_i);
  arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_i    (arb && if_req_i && !if_win),
    .clr_i    (if_win || !if_req_i),
    .at_max_o (at_max)
  );
  always_comb begin
    state_d     = new_rd ? WAIT : ret ? IDLE : state_q;
    owner_d     = if_win ? OWN_IF : new_rd ? OWN_D : owner_q;
    lat_d       = new_rd ? LAT_W'(1) : ret ? '0 : state_q == WAIT ? lat_q + 1'b1 : lat_q;
    killed_d    = if_win ? if_kill_i : killed_q || (if_kill_i && state_q == WAIT && owner_q == OWN_IF);
    if_gnt_o    = if_win;
    d_gnt_o     = d_win;
    if_rvalid_o = ret && owner_q == OWN_IF && !killed_q && !if_kill_i;
    d_rvalid_o  = ret && owner_q == OWN_D;
    if_rdata_o  = if_rvalid_o ? m_rdata_i : if_rdata_q;
    d_rdata_o   = d_rvalid_o ? m_rdata_i : d_rdata_q;
    m_addr_o    = if_win ? if_addr_i : d_win ? d_addr_i : '0;
    m_width_o   = d_win ? d_width_i : WIDTH_WORD;
    m_we_o      = d_win && d_we_i;
    m_wdata_o   = d_win ? d_wdata_i : '0;
    stall_if_o  = (if_req_i && !if_win) || (state_q == WAIT && owner_q == OWN_IF && !ret);
    stall_mem_o = (d_req_i && !d_win) || (state_q == WAIT && owner_q == OWN_D && !ret);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= OWN_D;
      lat_q      <= '0;
      killed_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_q      <= lat_d;
      killed_q   <= killed_d;
      if_rdata_q <= if_rdata_o;
      d_rdata_q  <= d_rdata_o;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random request traffic checked against a transaction-level model
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  localparam int SM  = 3;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 0, if_kill = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [2:0]  d_width = 0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, m_we, stall_if, stall_mem;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [2:0]  m_width;
  int checks = 0, errors = 0;
  bit pend, pend_if, pend_killed, rst_done, g_if, g_d;
  int issue, starve, cyc, n_if_rv, n_d_rv;
  logic [31:0] last_if, last_d;

  mem_port_arbiter #(.LAT(LAT), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_kill_i(if_kill),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_width_i(d_width), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .m_addr_o(m_addr), .m_width_o(m_width), .m_we_o(m_we), .m_wdata_o(m_wdata), .m_rdata_i(m_rdata),
    .stall_if_o(stall_if), .stall_mem_o(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " if_gnt"}, {31'b0, if_gnt}, 0);
    chk({tag, " d_gnt"}, {31'b0, d_gnt}, 0);
    chk({tag, " if_rvalid"}, {31'b0, if_rvalid}, 0);
    chk({tag, " d_rvalid"}, {31'b0, d_rvalid}, 0);
    chk({tag, " m_we"}, {31'b0, m_we}, 0);
    chk({tag, " m_width"}, {29'b0, m_width}, 32'h2);
    chk({tag, " m_addr"}, m_addr, 0);
    chk({tag, " m_wdata"}, m_wdata, 0);
    chk({tag, " if_rdata"}, if_rdata, 0);
    chk({tag, " d_rdata"}, d_rdata, 0);
  endtask

  task automatic model_reset();
    pend = 0; pend_if = 0; pend_killed = 0; starve = 0;
    last_if = 0; last_d = 0; g_if = 0; g_d = 0;
  endtask

  task automatic drive();
    if (!(if_req && !g_if) || $urandom_range(9) == 0) begin
      if_req  = $urandom_range(9) < 6;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!(d_req && !g_d) || $urandom_range(9) == 0) begin
      d_req   = $urandom_range(9) < 6;
      d_we    = $urandom_range(1);
      d_width = 3'($urandom_range(7));
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    if_kill = $urandom_range(7) == 0;
    m_rdata = $urandom;
  endtask

  task automatic step();
    bit ret, arb, e_ig, e_dg, e_irv, e_drv;
    ret   = pend && (cyc - issue == LAT);
    arb   = !pend || ret;
    e_ig  = arb && if_req && (starve == SM || !d_req);
    e_dg  = arb && d_req && !e_ig;
    e_irv = ret && pend_if && !pend_killed && !if_kill;
    e_drv = ret && !pend_if;
    if (e_irv) last_if = m_rdata;
    if (e_drv) last_d = m_rdata;
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_ig});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, e_dg});
    chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_irv});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, e_drv});
    chk("if_rdata", if_rdata, last_if);
    chk("d_rdata", d_rdata, last_d);
    chk("m_we", {31'b0, m_we}, {31'b0, e_dg && d_we});
    chk("m_width", {29'b0, m_width}, {29'b0, e_dg ? d_width : 3'b010});
    chk("stall_if", {31'b0, stall_if}, {31'b0, (if_req && !e_ig) || (pend && pend_if && !ret)});
    chk("stall_mem", {31'b0, stall_mem}, {31'b0, (d_req && !e_dg) || (pend && !pend_if && !ret)});
    if (e_ig) chk("m_addr_if", m_addr, if_addr);
    if (e_dg) chk("m_addr_d", m_addr, d_addr);
    if (e_dg && d_we) chk("m_wdata", m_wdata, d_wdata);
    n_if_rv += int'(e_irv);
    n_d_rv  += int'(e_drv);
    if (pend && pend_if && if_kill) pend_killed = 1;
    if (e_ig) begin
      pend = 1; pend_if = 1; issue = cyc; pend_killed = if_kill;
    end else if (e_dg && !d_we) begin
      pend = 1; pend_if = 0; issue = cyc; pend_killed = 0;
    end else if (ret) pend = 0;
    if (!if_req || e_ig) starve = 0;
    else if (arb && starve < SM) starve++;
    g_if = e_ig;
    g_d  = e_dg;
  endtask

  initial begin
    model_reset();
    cyc = 0; n_if_rv = 0; n_d_rv = 0; rst_done = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("por");
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (n > 0) @(negedge clk);
      rst_n = 1'b1;
      drive();
      if (!rst_done && n > 1500 && pend && cyc - issue == 2) begin
        // async reset mid-read: outputs must clear before any clock edge
        rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        rst_done = 1;
        model_reset();
        cyc++;
        continue;
      end
      #1 step();
      cyc++;
    end
    chk("midrst_reached", {31'b0, rst_done}, 1);
    chk("if_rv_seen", {31'b0, n_if_rv > 20}, 1);
    chk("d_rv_seen", {31'b0, n_d_rv > 20}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
